// File: rtl/sccomp_trace_pkg.sv
// Shared types and defaults for the single-cycle-computer trace buffer.
package sccomp_trace_pkg;

    // Default record field width and record capacity
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_DEPTH  = 16;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    // One retired-instruction record at the default field width
    typedef struct packed {
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] inst;
        logic [TRACE_DATA_W-1:0] addr;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset; the controller never exposes an
// entry that has not been written since the last flush.
module trace_ram #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming record on the rising edge when enabled
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sccomp_trace_buffer.sv
// Trace buffer for retired instructions: optional PC trigger, stop-when-full
// or wrap-around capture, and a first-word-fall-through read side.
module sccomp_trace_buffer
    import sccomp_trace_pkg::*;
#(
    parameter int DATA_W = TRACE_DATA_W,
    parameter int DEPTH  = TRACE_DEPTH
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]      in_inst,
    input  logic [DATA_W-1:0]      in_addr,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [DATA_W-1:0]      trig_pc,
    input  logic                   wrap_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_pc,
    output logic [DATA_W-1:0]      out_inst,
    output logic [DATA_W-1:0]      out_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   triggered,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 3 * DATA_W;

    trace_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             triggered_q, triggered_d;
    logic             overflow_q, overflow_d;
    logic             wrap_q, wrap_d;

    logic             ram_we;
    logic [REC_W-1:0] ram_rdata;
    logic             full;
    logic             pop;
    logic             push;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = (count_q != '0) && out_ready;
    assign push = in_valid &&
                  ((state_q == ST_CAPTURE) ||
                   ((state_q == ST_ARMED) && (in_pc == trig_pc)));

    trace_ram #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_in),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({in_pc, in_inst, in_addr}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rdata)
    );

    // Register controller state, pointers, occupancy and flags
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            wrap_q      <= wrap_d;
        end
    end

    // Next state: arm flushes and restarts; otherwise push/pop bookkeeping
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        wrap_d      = wrap_q;
        ram_we      = 1'b0;

        if (arm) begin
            // Any push or pop in the arm cycle is discarded by the flush.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            wrap_d     = wrap_mode;
            if (trig_en) begin
                state_d     = ST_ARMED;
                triggered_d = 1'b0;
            end else begin
                // Going straight to CAPTURE counts as capture having started.
                state_d     = ST_CAPTURE;
                triggered_d = 1'b1;
            end
        end else begin
            if (push) begin
                if (state_q == ST_ARMED) begin
                    state_d     = ST_CAPTURE;
                    triggered_d = 1'b1;
                end
                if (!full || pop) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end else if (wrap_q) begin
                    // Full with no pop: the oldest slot is the write slot.
                    ram_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            if (push && !pop && !full) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    assign out_valid = !reset && (count_q != '0);
    assign out_pc    = reset ? '0 : ram_rdata[REC_W-1 -: DATA_W];
    assign out_inst  = reset ? '0 : ram_rdata[2*DATA_W-1 -: DATA_W];
    assign out_addr  = reset ? '0 : ram_rdata[DATA_W-1:0];
    assign count     = count_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sccomp_trace_buffer.sv
// Directed bench for the trace buffer with a queue-based reference model.
module tb_sccomp_trace_buffer;

    localparam int DW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_pc, in_inst, in_addr;
    logic          arm, trig_en, wrap_mode, out_ready;
    logic [DW-1:0] trig_pc;
    logic          out_valid;
    logic [DW-1:0] out_pc, out_inst, out_addr;
    logic [2:0]    count;
    logic          triggered, overflow;

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] inst;
        logic [DW-1:0] addr;
    } rec_t;

    // Reference model: the buffer is just a bounded queue plus a mode
    rec_t mq[$];
    int   mMode;
    bit   mTrig, mOvf, mWrap, started;

    int testsRun    = 0;
    int testsFailed = 0;

    logic          curTe, curWm;
    logic [DW-1:0] curTpc;

    always #5 clk = ~clk;

    sccomp_trace_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk_in    (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_addr   (in_addr),
        .arm       (arm),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .wrap_mode (wrap_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .count     (count),
        .triggered (triggered),
        .overflow  (overflow)
    );

    function automatic logic [DW-1:0] instOf(logic [DW-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [DW-1:0] addrOf(logic [DW-1:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model update: modes are 0 idle, 1 waiting for trigger, 2 capturing, 3 stopped
    always @(posedge clk) begin : model
        rec_t r;
        bit   doPush, doPop;
        if (reset) begin
            mq.delete();
            mMode = 0;
            mTrig = 0;
            mOvf  = 0;
            mWrap = 0;
        end else if (arm) begin
            mq.delete();
            mOvf  = 0;
            mWrap = wrap_mode;
            mMode = trig_en ? 1 : 2;
            mTrig = !trig_en;
        end else begin
            doPop  = (mq.size() > 0) && out_ready;
            doPush = in_valid && (mMode == 2 || (mMode == 1 && in_pc == trig_pc));
            if (doPush && mMode == 1) begin
                mMode = 2;
                mTrig = 1;
            end
            if (doPop) r = mq.pop_front();
            if (doPush) begin
                r.pc   = in_pc;
                r.inst = in_inst;
                r.addr = in_addr;
                if (mq.size() < DP) begin
                    mq.push_back(r);
                end else if (mWrap) begin
                    void'(mq.pop_front());
                    mq.push_back(r);
                    mOvf = 1;
                end else begin
                    mOvf  = 1;
                    mMode = 3;
                end
            end
        end
        started = 1;
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (started) begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (!reset && mq.size() != 0)});
            checkOutput("count", {29'd0, count}, mq.size());
            checkOutput("triggered", {31'd0, triggered}, {31'd0, mTrig});
            checkOutput("overflow", {31'd0, overflow}, {31'd0, mOvf});
            if (reset) begin
                checkOutput("out_pc in reset", out_pc, '0);
                checkOutput("out_inst in reset", out_inst, '0);
                checkOutput("out_addr in reset", out_addr, '0);
            end else if (mq.size() != 0) begin
                checkOutput("out_pc", out_pc, mq[0].pc);
                checkOutput("out_inst", out_inst, mq[0].inst);
                checkOutput("out_addr", out_addr, mq[0].addr);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [DW-1:0] pc, input logic a, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = instOf(pc);
        in_addr   = addrOf(pc);
        arm       = a;
        trig_en   = curTe;
        trig_pc   = curTpc;
        wrap_mode = curWm;
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic armCapture(input logic te, input logic [DW-1:0] tpc, input logic wm);
        curTe  = te;
        curTpc = tpc;
        curWm  = wm;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic pushRec(input logic [DW-1:0] pc);
        applyStimulus(1'b1, pc, 1'b0, 1'b0);
    endtask

    task automatic popExpect(input string name, input logic [DW-1:0] expPc);
        checkOutput(name, out_pc, expPc);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        curTe = 0; curTpc = '0; curWm = 0;
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        // arm and push while reset is held must be ignored
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset count", {29'd0, count}, 32'd0);
        checkOutput("reset out_pc", out_pc, 32'd0);
        reset = 1'b0;
        pushRec(32'h48);
        checkOutput("idle ignores push", {29'd0, count}, 32'd0);
        checkOutput("idle triggered", {31'd0, triggered}, 32'd0);

        // No trigger: three records, then drain in order
        armCapture(1'b0, '0, 1'b0);
        checkOutput("untriggered arm sets triggered", {31'd0, triggered}, 32'd1);
        pushRec(32'h00); pushRec(32'h04); pushRec(32'h08);
        checkOutput("notrig count", {29'd0, count}, 32'd3);
        checkOutput("notrig head pc", out_pc, 32'h00);
        checkOutput("notrig head inst", out_inst, 32'hA5A5_0000);
        checkOutput("notrig head addr", out_addr, 32'h1000);
        popExpect("notrig pop0", 32'h00);
        popExpect("notrig pop1", 32'h04);
        popExpect("notrig pop2", 32'h08);
        checkOutput("notrig drained", {29'd0, count}, 32'd0);

        // Trigger on pc 0x10
        armCapture(1'b1, 32'h10, 1'b0);
        checkOutput("armed triggered", {31'd0, triggered}, 32'd0);
        for (int k = 0; k < 4; k++) pushRec(32'(k * 4));
        checkOutput("pre-trigger count", {29'd0, count}, 32'd0);
        checkOutput("pre-trigger flag", {31'd0, triggered}, 32'd0);
        pushRec(32'h10);
        checkOutput("trigger flag", {31'd0, triggered}, 32'd1);
        checkOutput("trigger count", {29'd0, count}, 32'd1);
        pushRec(32'h14); pushRec(32'h18);
        checkOutput("trig count", {29'd0, count}, 32'd3);
        popExpect("trig pop0", 32'h10);
        popExpect("trig pop1", 32'h14);
        popExpect("trig pop2", 32'h18);

        // Stop mode: fifth record dropped, capture stops
        armCapture(1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) pushRec(32'h100 + 32'(k * 4));
        checkOutput("stop count", {29'd0, count}, 32'd4);
        checkOutput("stop overflow", {31'd0, overflow}, 32'd1);
        pushRec(32'h200);
        checkOutput("done holds count", {29'd0, count}, 32'd4);
        checkOutput("stop head", out_pc, 32'h100);
        applyStimulus(1'b1, 32'h204, 1'b0, 1'b1);
        checkOutput("done pop ignores push", {29'd0, count}, 32'd3);
        popExpect("stop pop1", 32'h104);
        popExpect("stop pop2", 32'h108);
        popExpect("stop pop3", 32'h10C);

        // Wrap mode: six records, oldest two overwritten
        armCapture(1'b0, '0, 1'b1);
        for (int k = 0; k < 6; k++) pushRec(32'h200 + 32'(k * 4));
        checkOutput("wrap count", {29'd0, count}, 32'd4);
        checkOutput("wrap overflow", {31'd0, overflow}, 32'd1);
        popExpect("wrap pop0", 32'h208);
        popExpect("wrap pop1", 32'h20C);
        popExpect("wrap pop2", 32'h210);
        popExpect("wrap pop3", 32'h214);

        // Full with simultaneous push and pop
        armCapture(1'b0, '0, 1'b0);
        checkOutput("arm clears overflow", {31'd0, overflow}, 32'd0);
        for (int k = 0; k < 4; k++) pushRec(32'h300 + 32'(k * 4));
        checkOutput("full head", out_pc, 32'h300);
        applyStimulus(1'b1, 32'h310, 1'b0, 1'b1);
        checkOutput("full pp count", {29'd0, count}, 32'd4);
        checkOutput("full pp overflow", {31'd0, overflow}, 32'd0);
        checkOutput("full pp new head", out_pc, 32'h304);

        // Re-arm mid-capture with a push in the arm cycle
        armCapture(1'b0, '0, 1'b0);
        pushRec(32'h400); pushRec(32'h404);
        checkOutput("mid count", {29'd0, count}, 32'd2);
        curTe = 1'b1; curTpc = 32'h999;
        applyStimulus(1'b1, 32'h408, 1'b1, 1'b1);
        checkOutput("rearm count", {29'd0, count}, 32'd0);
        checkOutput("rearm triggered", {31'd0, triggered}, 32'd0);
        checkOutput("rearm overflow", {31'd0, overflow}, 32'd0);

        // Reset mid-capture with a push in the reset cycle
        armCapture(1'b0, '0, 1'b0);
        pushRec(32'h500); pushRec(32'h504);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h508, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("reset mid count", {29'd0, count}, 32'd0);
        checkOutput("reset mid triggered", {31'd0, triggered}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
